// File: rtl/carry_select_subtractor_seq_if.sv
// Valid/ready operand and result bundle for the sequential carry-select subtractor.
// The master side issues operands and consumes results; the slave side is the subtractor.
interface carry_select_subtractor_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, zero
  );
endinterface

// File: rtl/carry_select_subtractor_seq.sv
// Multi-cycle subtractor: diff = a - b - bin, one 4-bit slice per clock, LSB first.
// Each slice precomputes both borrow-in variants; the registered borrow selects one.
module carry_select_subtractor_seq #(
  parameter int WIDTH = 16
) (
  input logic                          clk,
  input logic                          rst_n,
  carry_select_subtractor_seq_if.slave bus
);
  localparam int SLICES = WIDTH / 4;
  localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [3:0]       a_sl, b_sl;
  logic [4:0]       s0, s1, sel;
  logic [WIDTH-1:0] diff_upd;

  // Slice datapath plus next-state/next-output decode for the IDLE/RUN/DONE sequencer.
  always_comb begin
    // NOTE: every _d starts from its _q so no branch leaves a signal unassigned (no latches).
    state_d = state_q;
    idx_d   = idx_q;
    brw_d   = brw_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    // Current slice; s1[4]/s0[4] is the inverted borrow-out of each variant.
    a_sl = a_q[{idx_q, 2'b00} +: 4];
    b_sl = b_q[{idx_q, 2'b00} +: 4];
    s0   = {1'b0, a_sl} + {1'b0, ~b_sl} + 5'd1;
    s1   = {1'b0, a_sl} + {1'b0, ~b_sl};
    sel  = brw_q ? s1 : s0;

    diff_upd                     = diff_q;
    diff_upd[{idx_q, 2'b00} +: 4] = sel[3:0];

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          brw_d   = bus.bin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d = diff_upd;
        brw_d  = ~sel[4];
        idx_d  = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          bout_d  = ~sel[4];
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_upd[WIDTH-1] != a_q[WIDTH-1]);
          zero_d  = (diff_upd == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      brw_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      state_q <= state_d;
      idx_q   <= idx_d;
      brw_q   <= brw_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  // Handshakes come from registered state only: no combinational input-to-output path.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_carry_select_subtractor_seq.sv
// Scoreboard bench for carry_select_subtractor_seq (WIDTH=16): the driver pushes expected
// results, an independent monitor pops and compares on every result handoff.
module tb_carry_select_subtractor_seq;
  localparam int W = 16;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   rdy_rand = 1'b0;
  exp_t sb[$];

  carry_select_subtractor_seq_if #(.WIDTH(W)) ifc ();

  carry_select_subtractor_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    logic [W:0] r;
    exp_t e;
    r      = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    e.diff = r[W-1:0];
    e.bout = r[W];
    e.ovf  = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    e.zero = (r[W-1:0] == '0);
    e.acc  = 0;
    return e;
  endfunction

  function automatic exp_t hand(input logic [W-1:0] d, input logic bo, input logic ov, input logic z);
    exp_t e;
    e.diff = d;
    e.bout = bo;
    e.ovf  = ov;
    e.zero = z;
    e.acc  = 0;
    return e;
  endfunction

  // Random out_ready stalls, active only during the random phase.
  always @(posedge clk) begin
    #1;
    if (rdy_rand) ifc.out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: latency check on out_valid rising, full compare on each handoff.
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (ifc.out_valid && !prev_ov) begin
      if (sb.size() == 0) check("unexpected_out_valid", 1, 0);
      else begin
        check("latency", 32'(cyc - sb[0].acc), 32'd4);
        check("in_ready_low_in_done", {31'd0, ifc.in_ready}, 32'd0);
      end
    end
    if (ifc.out_valid && ifc.out_ready && sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check("result", {12'd0, ifc.diff, ifc.bout, ifc.ovf, ifc.zero, 1'b0},
            {12'd0, e.diff, e.bout, e.ovf, e.zero, 1'b0});
    end
    prev_ov = ifc.out_valid;
  end

  // Caller is at posedge+1; waits for in_ready, offers one op, then scrambles the operand bus.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi, input exp_t e);
    int n = 0;
    while (!ifc.in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!ifc.in_ready) begin
      check("issue_timeout", 0, 1);
      return;
    end
    ifc.in_valid = 1'b1;
    ifc.a        = a;
    ifc.b        = b;
    ifc.bin      = bi;
    e.acc        = cyc + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    ifc.a        = W'($urandom);
    ifc.b        = W'($urandom);
    ifc.bin      = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !ifc.in_ready) && n < 400) begin
      @(posedge clk); #1; n++;
    end
    check("drain_empty", 32'(sb.size()), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rbi;
    int           n;

    rst_n         = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.a         = '0;
    ifc.b         = '0;
    ifc.bin       = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state.
    check("rst_in_ready", {31'd0, ifc.in_ready}, 1);
    check("rst_out_valid", {31'd0, ifc.out_valid}, 0);
    check("rst_outputs", {12'd0, ifc.diff, ifc.bout, ifc.ovf, ifc.zero, 1'b0}, 0);

    // 1: simple subtract, in_ready low while busy.
    issue(16'h1234, 16'h0234, 1'b0, hand(16'h1000, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      check("busy_in_ready", {31'd0, ifc.in_ready}, 0);
      check("busy_out_valid", {31'd0, ifc.out_valid}, 0);
      @(posedge clk); #1;
    end
    drain();

    // 2-4: borrow ripple, signed overflow, zero, borrow-in cases.
    issue(16'h0000, 16'h0001, 1'b0, hand(16'hFFFF, 1'b1, 1'b0, 1'b0));
    issue(16'h8000, 16'h0001, 1'b0, hand(16'h7FFF, 1'b0, 1'b1, 1'b0));
    issue(16'h7FFF, 16'hFFFF, 1'b0, hand(16'h8000, 1'b1, 1'b1, 1'b0));
    issue(16'h00FF, 16'h00FE, 1'b1, hand(16'h0000, 1'b0, 1'b0, 1'b1));
    issue(16'h0000, 16'h0000, 1'b1, hand(16'hFFFF, 1'b1, 1'b0, 1'b0));
    drain();

    // 5: stall in DONE with new operands offered.
    ifc.out_ready = 1'b0;
    issue(16'h5555, 16'h1111, 1'b0, hand(16'h4444, 1'b0, 1'b0, 1'b0));
    n = 0;
    while (!ifc.out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("stall_reached_done", {31'd0, ifc.out_valid}, 1);
    ifc.in_valid = 1'b1;
    ifc.a        = 16'h0003;
    ifc.b        = 16'h0001;
    ifc.bin      = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("stall_out_valid", {31'd0, ifc.out_valid}, 1);
      check("stall_in_ready", {31'd0, ifc.in_ready}, 0);
      check("stall_diff", {16'd0, ifc.diff}, 32'h4444);
    end
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", {31'd0, ifc.in_ready}, 1);
    check("release_out_valid", {31'd0, ifc.out_valid}, 0);
    begin
      exp_t e;
      e     = hand(16'h0002, 1'b0, 1'b0, 1'b0);
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    check("pending_accepted", {31'd0, ifc.in_ready}, 0);
    drain();

    // 6: reset while in RUN at idx=2; partial result is discarded.
    ifc.in_valid = 1'b1;
    ifc.a        = 16'h1234;
    ifc.b        = 16'h4321;
    ifc.bin      = 1'b1;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrun_rst_out_valid", {31'd0, ifc.out_valid}, 0);
    check("midrun_rst_in_ready", {31'd0, ifc.in_ready}, 1);
    check("midrun_rst_outputs", {12'd0, ifc.diff, ifc.bout, ifc.ovf, ifc.zero, 1'b0}, 0);
    issue(16'hFFFF, 16'h0001, 1'b0, hand(16'hFFFE, 1'b0, 1'b0, 1'b0));
    drain();

    // Random ops with random out_ready stalls against the reference model.
    rdy_rand = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra  = W'($urandom);
      rb  = (i % 16 == 0) ? ra : W'($urandom);
      rbi = 1'($urandom_range(0, 1));
      issue(ra, rb, rbi, model(ra, rb, rbi));
    end
    rdy_rand = 1'b0;
    @(posedge clk); #2;
    ifc.out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
